// File: rtl/sync_fifo_buffer.sv
// Single-clock FIFO with registered read data, occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_buffer #(
  parameter int unsigned DATA_SIZE     = 8,
  parameter int unsigned ADDR_SIZE     = 4,
  parameter int unsigned AFULL_THRESH  = (1 << ADDR_SIZE) - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 winc,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic                 wfull,
  output logic                 walmost_full,
  input  logic                 rinc,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 rvalid,
  output logic                 rempty,
  output logic                 ralmost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clr_err
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] AF_TH = (ADDR_SIZE + 1)'(AFULL_THRESH);
  localparam logic [ADDR_SIZE:0] AE_TH = (ADDR_SIZE + 1)'(AEMPTY_THRESH);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE:0]   wptr;
  logic [ADDR_SIZE:0]   rptr;
  logic                 we;
  logic                 re;

  // Status comes from the registered pointers only; the extra MSB tells
  // a full lap apart from an empty one.
  always_comb begin
    count         = wptr - rptr;
    rempty        = (wptr == rptr);
    wfull         = (wptr[ADDR_SIZE] != rptr[ADDR_SIZE]) &&
                    (wptr[ADDR_SIZE-1:0] == rptr[ADDR_SIZE-1:0]);
    walmost_full  = (count >= AF_TH);
    ralmost_empty = (count <= AE_TH);
    we            = winc & ~wfull;
    re            = rinc & ~rempty;
  end

  always_ff @(posedge wclk) begin
    if (we) begin
      mem[wptr[ADDR_SIZE-1:0]] <= wdata;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr <= '0;
    end else if (we) begin
      wptr <= wptr + 1'b1;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rptr   <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        rdata <= mem[rptr[ADDR_SIZE-1:0]];
        rptr  <= rptr + 1'b1;
      end
    end
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~clr_err) | (winc & wfull);
      underflow <= (underflow & ~clr_err) | (rinc & rempty);
    end
  end

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Randomised scoreboard bench for sync_fifo_buffer: a queue-based model predicts
// status and read data; a negedge monitor pops expected words on rvalid.
module tb_sync_fifo_buffer;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 14;
  localparam int unsigned AE    = 2;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic          winc = 1'b0;
  logic          rinc = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          wfull, walmost_full, rvalid, rempty, ralmost_empty;
  logic          overflow, underflow;
  logic [AW:0]   count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  sync_fifo_buffer #(
    .DATA_SIZE(DW),
    .ADDR_SIZE(AW),
    .AFULL_THRESH(AF),
    .AEMPTY_THRESH(AE)
  ) dut (
    .wclk(wclk),
    .wrst_n(wrst_n),
    .winc(winc),
    .wdata(wdata),
    .wfull(wfull),
    .walmost_full(walmost_full),
    .rinc(rinc),
    .rdata(rdata),
    .rvalid(rvalid),
    .rempty(rempty),
    .ralmost_empty(ralmost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow),
    .clr_err(clr_err)
  );

  always #5 wclk = ~wclk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic check_status();
    int unsigned n;
    n = model_q.size();
    chk("count", 32'(count), n);
    chk("wfull", 32'(wfull), 32'(n == DEPTH));
    chk("rempty", 32'(rempty), 32'(n == 0));
    chk("walmost_full", 32'(walmost_full), 32'(n >= AF));
    chk("ralmost_empty", 32'(ralmost_empty), 32'(n <= AE));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
  endtask

  // One clock: drive inputs, advance the model, push any expected read word
  // just after the edge, then check status at edge+1.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d,
                       input logic clr);
    logic          full, empty, acc_r;
    logic [DW-1:0] rd;
    full  = (model_q.size() == DEPTH);
    empty = (model_q.size() == 0);
    acc_r = r && !empty;
    rd    = '0;
    winc = w; rinc = r; wdata = d; clr_err = clr;
    if (acc_r) rd = model_q.pop_front();
    if (w && !full) model_q.push_back(d);
    m_ovf = (m_ovf && !clr) || (w && full);
    m_udf = (m_udf && !clr) || (r && empty);
    @(posedge wclk);
    if (acc_r) exp_q.push_back(rd);
    #1;
    check_status();
  endtask

  task automatic idle();
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
  endtask

  always @(negedge wclk) begin
    if (wrst_n) begin
      if (exp_q.size() != 0) begin
        chk("rvalid", 32'(rvalid), 32'd1);
        if (rvalid) chk("rdata", 32'(rdata), 32'(exp_q[0]));
        exp_q.delete();
      end else begin
        chk("rvalid_idle", 32'(rvalid), 32'd0);
      end
    end
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_rempty"}, 32'(rempty), 32'd1);
    chk({tag, "_ralmost_empty"}, 32'(ralmost_empty), 32'd1);
    chk({tag, "_wfull"}, 32'(wfull), 32'd0);
    chk({tag, "_walmost_full"}, 32'(walmost_full), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_underflow"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    logic w, r;
    repeat (3) @(posedge wclk);
    #1;
    check_reset_outputs("reset");
    wrst_n = 1'b1;

    // Fill with 0x00..0x0F
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);
    // Write while full
    cycle(1'b1, 1'b0, 8'h77, 1'b0);
    // Clear with no new error
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    // Simultaneous push/pop while full: pops 0x00, 0xAA rejected
    cycle(1'b1, 1'b1, 8'hAA, 1'b0);
    cycle(1'b1, 1'b0, 8'h33, 1'b1);
    // Drain remaining 16 words (0x01..0x0F then 0x33)
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    // Read while empty, then clear coinciding with a new underflow
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    // Simultaneous push/pop while empty
    cycle(1'b1, 1'b1, 8'h55, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Random traffic across pointer wrap, occupancy kept within 3..13
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      r = 1'($urandom);
      if (model_q.size() <= 3) r = 1'b0;
      if (model_q.size() >= 13) w = 1'b0;
      cycle(w, r, DW'($urandom), 1'b0);
    end

    // Asynchronous reset between edges with traffic in flight
    winc = 1'b1; rinc = 1'b1; wdata = 8'hC3;
    #2;
    wrst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_q.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    idle();
    repeat (2) @(posedge wclk);
    #1;
    check_reset_outputs("midrst_hold");
    wrst_n = 1'b1;

    // Normal operation after release
    cycle(1'b1, 1'b0, 8'h5A, 1'b0);
    cycle(1'b1, 1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    idle();
    @(posedge wclk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
